ext_bus_target: RTL and testbench

Synthesizable, parametrised target for the byte-wide Microwatt external bus: decodes read/write commands from the bus master, backs them with an internal word-addressed memory honouring byte selects, and returns acks and read data with a configurable read latency. Adds per-byte odd-parity checking with an error-ack response and a sticky error counter. Used as an on-chip or FPGA-side endpoint for bus bring-up and as a reusable model in system-level benches.

---
 rtl/ext_bus_target.sv | 203 ++++++++++++++++++++
 tb/tb_ext_bus_target.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_target.sv
// Byte-wide Microwatt external bus target backed by an internal word memory.
// Odd parity is checked on every inbound byte; errors abort with ERR_ACK and are counted.
module ext_bus_target #(
   parameter int unsigned ADDR_BYTES = 4,
   parameter int unsigned DATA_BYTES = 8,
   parameter int unsigned MEM_WORDS  = 16,
   parameter int unsigned READ_DELAY = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] bus_in,
   input  logic       bus_pty_in,
   output logic [7:0] bus_out,
   output logic       bus_pty_out,
   output logic       busy,
   output logic       err,
   output logic [7:0] err_count,
   input  logic       err_clr
);

   localparam int unsigned AW = ADDR_BYTES * 8;
   localparam int unsigned DW = DATA_BYTES * 8;
   localparam int unsigned TW = DW + 8;
   localparam int unsigned OW = $clog2(DATA_BYTES);
   localparam int unsigned IW = $clog2(MEM_WORDS);
   localparam int unsigned EW = (AW > OW + IW) ? AW : OW + IW;

   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] CMD_WRITE = 8'h03;
   localparam logic [7:0] READ_ACK  = 8'h82;
   localparam logic [7:0] WRITE_ACK = 8'h83;
   localparam logic [7:0] ERR_ACK   = 8'h8F;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEL, S_DATA, S_DELAY, S_TX} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  op_wr_q, op_wr_d;
   logic [DATA_BYTES-1:0] sel_q, sel_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic [TW-1:0]         tx_q, tx_d;
   logic [7:0]            bus_out_q, bus_out_d;
   logic                  err_q, err_d;
   logic [7:0]            err_count_q, err_count_d;

   logic [DW-1:0] mem_q [MEM_WORDS];

   logic          pty_err;
   logic          mem_we;
   logic [AW+7:0] acat;
   logic [DW+7:0] wcat;
   logic [EW-1:0] addr_x;
   logic [IW-1:0] widx;
   logic [DW-1:0] rword;
   logic          unused_ok;

   // Address and write data shift in from the top so the first byte ends up in lane 0.
   always_comb begin
      pty_err = (bus_pty_in != ~^bus_in);
      acat    = {bus_in, addr_q} >> 8;
      wcat    = {bus_in, wdata_q} >> 8;
      addr_x  = EW'(addr_q);
      widx    = addr_x[OW +: IW];
      rword   = mem_q[widx];
   end

   assign unused_ok = ^{addr_x, acat[AW+7:AW], wcat[DW+7:DW]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      op_wr_d   = op_wr_q;
      sel_d     = sel_q;
      wdata_d   = wdata_q;
      tx_d      = tx_q;
      bus_out_d = '0;
      mem_we    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus_in == CMD_WRITE || bus_in == CMD_READ) begin
               state_d = S_ADDR;
               cnt_d   = 8'(ADDR_BYTES);
               addr_d  = '0;
               op_wr_d = (bus_in == CMD_WRITE);
            end
         end
         S_ADDR: begin
            addr_d = acat[AW-1:0];
            if (cnt_q == 8'd1) begin
               if (op_wr_q) begin
                  state_d = S_SEL;
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = 8'(READ_DELAY);
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_SEL: begin
            sel_d   = bus_in[DATA_BYTES-1:0];
            state_d = S_DATA;
            cnt_d   = 8'(DATA_BYTES);
         end
         S_DATA: begin
            wdata_d = wcat[DW-1:0];
            if (cnt_q == 8'd1) begin
               mem_we  = 1'b1;
               state_d = S_TX;
               tx_d    = TW'(WRITE_ACK);
               cnt_d   = 8'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DELAY: begin
            if (cnt_q == 8'd1) begin
               state_d = S_TX;
               tx_d    = {rword, READ_ACK};
               cnt_d   = 8'(DATA_BYTES + 1);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_TX: begin
            bus_out_d = tx_q[7:0];
            tx_d      = tx_q >> 8;
            if (cnt_q == 8'd1) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A bad byte outside TX overrides whatever the state wanted, including the memory write.
      if (pty_err && state_q != S_TX) begin
         state_d   = S_TX;
         tx_d      = TW'(ERR_ACK);
         cnt_d     = 8'd1;
         mem_we    = 1'b0;
         bus_out_d = '0;
      end
   end

   always_comb begin
      err_d       = err_q;
      err_count_d = err_count_q;
      if (err_clr) begin
         err_d       = 1'b0;
         err_count_d = '0;
      end else if (pty_err) begin
         err_d = 1'b1;
         if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         op_wr_q     <= 1'b0;
         sel_q       <= '0;
         wdata_q     <= '0;
         tx_q        <= '0;
         bus_out_q   <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         op_wr_q     <= op_wr_d;
         sel_q       <= sel_d;
         wdata_q     <= wdata_d;
         tx_q        <= tx_d;
         bus_out_q   <= bus_out_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (sel_q[k]) mem_q[widx][k*8 +: 8] <= wcat[k*8 +: 8];
         end
      end
   end

   assign bus_out     = bus_out_q;
   assign bus_pty_out = ~^bus_out_q;
   assign busy        = (state_q != S_IDLE);
   assign err         = err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// Scoreboard bench for ext_bus_target: stimulus pushes timed expected bytes,
// a negedge monitor pops and compares every cycle (bus_out must be 0 otherwise).
module tb_ext_bus_target;

   localparam int AB = 4;
   localparam int DB = 8;
   localparam int MW = 16;
   localparam int RD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bus_in;
   logic       bus_pty_in;
   logic [7:0] bus_out;
   logic       bus_pty_out;
   logic       busy;
   logic       err;
   logic [7:0] err_count;
   logic       err_clr;

   always #5 clk = ~clk;

   ext_bus_target #(
      .ADDR_BYTES(AB),
      .DATA_BYTES(DB),
      .MEM_WORDS (MW),
      .READ_DELAY(RD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_in     (bus_in),
      .bus_pty_in (bus_pty_in),
      .bus_out    (bus_out),
      .bus_pty_out(bus_pty_out),
      .busy       (busy),
      .err        (err),
      .err_count  (err_count),
      .err_clr    (err_clr)
   );

   typedef struct {int cyc; logic [7:0] val;} exp_t;
   typedef logic [7:0] word_t [DB];

   exp_t       expq[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 1'b0;
   logic [7:0] mdl [MW][DB];
   bit         err_m = 1'b0;
   int         err_cnt_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL lost_byte cyc=%0d got=none expected=%0h@%0d", cyc, expq[0].val, expq[0].cyc);
            void'(expq.pop_front());
         end
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            exp_t x;
            x = expq.pop_front();
            chk("bus_out", bus_out, x.val);
            chk("bus_pty_out", bus_pty_out, ~^x.val);
         end else begin
            chk("bus_out_idle", bus_out, 8'h00);
            chk("bus_pty_idle", bus_pty_out, 1'b1);
         end
      end
   end

   task automatic push(input int c, input logic [7:0] v);
      exp_t x;
      x.cyc = c;
      x.val = v;
      expq.push_back(x);
   endtask

   function automatic int word_of(input longint a);
      longint m;
      m = a & ((64'd1 << (8 * AB)) - 1);
      return int'((m / DB) % MW);
   endfunction

   task automatic drive(input logic [7:0] b, input bit bad, output int e);
      bus_in     = b;
      bus_pty_in = bad ? (^b) : ~(^b);
      @(posedge clk);
      #1;
      e = cyc;
      if (err_clr) begin
         err_m     = 1'b0;
         err_cnt_m = 0;
      end else if (bad) begin
         err_m = 1'b1;
         if (err_cnt_m < 255) err_cnt_m++;
      end
      bus_in     = 8'h00;
      bus_pty_in = 1'b1;
   endtask

   // Random good-parity bytes while the target is busy; they must be ignored.
   task automatic filler(input int n, input int bad_at);
      int e;
      for (int j = 0; j < n; j++) drive(8'($urandom), j == bad_at, e);
   endtask

   task automatic idle(input int n);
      int e;
      logic [7:0] b;
      for (int j = 0; j < n; j++) begin
         b = 8'($urandom);
         if (b == 8'h02 || b == 8'h03) b = 8'h00;
         drive(b, 1'b0, e);
      end
   endtask

   task automatic check_status();
      chk("err", err, err_m);
      chk("err_count", err_count, err_cnt_m);
   endtask

   task automatic wr(input longint addr, input logic [7:0] selb, input word_t d, input int abort_at);
      logic [7:0] seq[$];
      int e;
      int w;
      seq.push_back(8'h03);
      for (int i = 0; i < AB; i++) seq.push_back(8'(addr >> (8 * i)));
      seq.push_back(selb);
      for (int k = 0; k < DB; k++) seq.push_back(d[k]);
      for (int i = 0; i < seq.size(); i++) begin
         drive(seq[i], i == abort_at, e);
         if (i == abort_at) begin
            push(e + 1, 8'h8F);
            filler(1, -1);
            return;
         end
      end
      push(e + 1, 8'h83);
      w = word_of(addr);
      for (int k = 0; k < DB; k++) if (selb[k]) mdl[w][k] = d[k];
      filler(1, -1);
   endtask

   task automatic rd(input longint addr, input int abort_at, input bit tx_bad);
      logic [7:0] seq[$];
      int e;
      int w;
      seq.push_back(8'h02);
      for (int i = 0; i < AB; i++) seq.push_back(8'(addr >> (8 * i)));
      for (int i = 0; i < seq.size(); i++) begin
         drive(seq[i], i == abort_at, e);
         if (i == abort_at) begin
            push(e + 1, 8'h8F);
            filler(1, -1);
            return;
         end
      end
      w = word_of(addr);
      push(e + RD + 1, 8'h82);
      for (int k = 0; k < DB; k++) push(e + RD + 2 + k, mdl[w][k]);
      filler(RD + 1 + DB, tx_bad ? RD + 1 : -1);
   endtask

   initial begin : stim
      word_t d;
      int e;
      rst        = 1'b1;
      bus_in     = 8'h00;
      bus_pty_in = 1'b1;
      err_clr    = 1'b0;
      for (int w = 0; w < MW; w++) for (int k = 0; k < DB; k++) mdl[w][k] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_out", bus_out, 8'h00);
      chk("rst_bus_pty_out", bus_pty_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      check_status();
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(20);
      chk("idle_busy", busy, 1'b0);
      check_status();

      // Define every memory word before any read.
      for (int w = 0; w < MW; w++) begin
         for (int k = 0; k < DB; k++) d[k] = 8'($urandom);
         wr(longint'(w * DB), 8'hFF, d, -1);
      end

      for (int k = 0; k < DB; k++) d[k] = 8'(k + 1);
      wr(64'h10, 8'hFF, d, -1);
      rd(64'h10, -1, 1'b0);
      for (int k = 0; k < DB; k++) d[k] = 8'hAA;
      wr(64'h10, 8'h0F, d, -1);
      rd(64'h10, -1, 1'b0);
      for (int k = 0; k < DB; k++) d[k] = 8'($urandom);
      wr(64'h90, 8'hFF, d, -1);
      rd(64'h10, -1, 1'b0);

      // Bad parity on the second address byte aborts the write.
      for (int k = 0; k < DB; k++) d[k] = 8'($urandom);
      wr(64'h10, 8'hFF, d, 2);
      check_status();
      rd(64'h10, -1, 1'b0);

      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check_status();

      // Clear wins over a same-cycle parity error, which still draws ERR_ACK.
      err_clr = 1'b1;
      drive(8'h00, 1'b1, e);
      err_clr = 1'b0;
      push(e + 1, 8'h8F);
      filler(1, -1);
      check_status();

      for (int i = 0; i < 260; i++) begin
         drive(8'h00, 1'b1, e);
         push(e + 1, 8'h8F);
         filler(1, -1);
      end
      check_status();
      chk("err_count_sat", err_count, 8'hFF);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check_status();

      rd(64'h18, -1, 1'b1);
      check_status();

      // Reset while the read is waiting in DELAY: no ack ever appears.
      drive(8'h02, 1'b0, e);
      for (int i = 0; i < AB; i++) drive(8'(32'h20 >> (8 * i)), 1'b0, e);
      filler(RD >= 3 ? 2 : 0, -1);
      rst = 1'b1;
      drive(8'h00, 1'b0, e);
      rst       = 1'b0;
      err_m     = 1'b0;
      err_cnt_m = 0;
      chk("rst_mid_busy", busy, 1'b0);
      check_status();
      idle(3);
      for (int k = 0; k < DB; k++) d[k] = 8'($urandom);
      wr(64'h20, 8'hFF, d, -1);
      rd(64'h20, -1, 1'b0);

      for (int t = 0; t < 200; t++) begin
         longint a;
         int ab;
         a  = longint'($urandom);
         ab = ($urandom_range(0, 7) == 0) ? 1 : 0;
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k < DB; k++) d[k] = 8'($urandom);
            wr(a, 8'($urandom), d, ab ? $urandom_range(0, AB + 1 + DB) : -1);
         end else begin
            rd(a, ab ? $urandom_range(0, AB) : -1, $urandom_range(0, 9) == 0);
         end
         if ($urandom_range(0, 15) == 0) begin
            err_clr = 1'b1;
            idle(1);
            err_clr = 1'b0;
         end
         check_status();
         idle($urandom_range(0, 3));
      end

      for (int i = 0; i < 200 && expq.size() > 0; i++) @(posedge clk);
      if (expq.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain got=%0d pending expected=0", expq.size());
      end
      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
